// File: rtl/vga_bar_render.sv
// rtl/vga_bar_render.sv - biofeedback level bar, threshold marker and background renderer
module vga_bar_render #(
    parameter int          BAR_X    = 304,
    parameter int          BAR_W    = 32,
    parameter int          STEP     = 4,
    parameter int          WARN     = 160,
    parameter logic [7:0]  BG_COLOR = 8'h02
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] hc,
    input  logic [9:0] vc,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic [7:0] level_in,
    input  logic       level_valid,
    output logic       level_ready,
    output logic [7:0] rgb,
    output logic       hsync_out,
    output logic       vsync_out,
    output logic       frame_tick
);

    localparam logic [9:0] BAR_L  = 10'(BAR_X);
    localparam logic [9:0] BAR_R  = 10'(BAR_X + BAR_W - 1);
    localparam logic [9:0] MK_L   = 10'(BAR_X - 4);
    localparam logic [9:0] MK_R   = 10'(BAR_X + BAR_W + 3);
    localparam logic [9:0] MK_ROW = 10'(480 - ((2 * WARN > 480) ? 480 : 2 * WARN));
    localparam logic [8:0] STEP9  = 9'(STEP);

    logic [7:0] pending_q, pending_d;
    logic       pending_full_q, pending_full_d;
    logic [7:0] target_q, target_d;
    logic [7:0] disp_q, disp_d;
    logic       frame_tick_q, frame_tick_d;

    logic       s1_active_q, s1_active_d;
    logic       s1_marker_q, s1_marker_d;
    logic       s1_bar_q, s1_bar_d;
    logic       s1_red_q, s1_red_d;
    logic       s1_hs_q, s1_hs_d;
    logic       s1_vs_q, s1_vs_d;

    logic [7:0] rgb_q, rgb_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;

    logic       commit, slew, accept;
    logic [8:0] up_sum, dn_diff, h2, height, bar_top;

    always_comb begin
        commit = (hc == 10'd0) && (vc == 10'd480);
        slew   = (hc == 10'd1) && (vc == 10'd480);
        accept = level_valid && !pending_full_q;

        pending_d      = pending_q;
        pending_full_d = pending_full_q;
        target_d       = target_q;
        frame_tick_d   = commit;

        // Ready is low while full, so a commit that drains pending never races an accept.
        if (commit && pending_full_q) begin
            target_d       = pending_q;
            pending_full_d = 1'b0;
        end
        if (accept) begin
            pending_d      = level_in;
            pending_full_d = 1'b1;
        end

        up_sum  = {1'b0, disp_q} + STEP9;
        dn_diff = {1'b0, disp_q} - STEP9;
        disp_d  = disp_q;
        if (slew) begin
            if (disp_q < target_q) begin
                disp_d = (up_sum > {1'b0, target_q}) ? target_q : up_sum[7:0];
            end else if (disp_q > target_q) begin
                disp_d = (dn_diff[8] || (dn_diff[7:0] < target_q)) ? target_q : dn_diff[7:0];
            end
        end

        // Bar grows upward from the bottom row; two lines per level unit, clamped to full height.
        h2      = {disp_q, 1'b0};
        height  = (h2 > 9'd480) ? 9'd480 : h2;
        bar_top = 9'd480 - height;

        s1_active_d = (hc < 10'd640) && (vc < 10'd480);
        s1_marker_d = (vc == MK_ROW) && (hc >= MK_L) && (hc <= MK_R);
        s1_bar_d    = (hc >= BAR_L) && (hc <= BAR_R) && (vc >= {1'b0, bar_top}) && (vc < 10'd480);
        s1_red_d    = ({1'b0, disp_q} >= 9'(WARN));
        s1_hs_d     = hsync_in;
        s1_vs_d     = vsync_in;

        if (!s1_active_q) begin
            rgb_d = 8'h00;
        end else if (s1_marker_q) begin
            rgb_d = 8'hFF;
        end else if (s1_bar_q) begin
            rgb_d = s1_red_q ? 8'hE0 : 8'h1C;
        end else begin
            rgb_d = BG_COLOR;
        end
        hs_d = s1_hs_q;
        vs_d = s1_vs_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q      <= 8'd0;
            pending_full_q <= 1'b0;
            target_q       <= 8'd0;
            disp_q         <= 8'd0;
            frame_tick_q   <= 1'b0;
            s1_active_q    <= 1'b0;
            s1_marker_q    <= 1'b0;
            s1_bar_q       <= 1'b0;
            s1_red_q       <= 1'b0;
            s1_hs_q        <= 1'b1;
            s1_vs_q        <= 1'b1;
            rgb_q          <= 8'h00;
            hs_q           <= 1'b1;
            vs_q           <= 1'b1;
        end else begin
            pending_q      <= pending_d;
            pending_full_q <= pending_full_d;
            target_q       <= target_d;
            disp_q         <= disp_d;
            frame_tick_q   <= frame_tick_d;
            s1_active_q    <= s1_active_d;
            s1_marker_q    <= s1_marker_d;
            s1_bar_q       <= s1_bar_d;
            s1_red_q       <= s1_red_d;
            s1_hs_q        <= s1_hs_d;
            s1_vs_q        <= s1_vs_d;
            rgb_q          <= rgb_d;
            hs_q           <= hs_d;
            vs_q           <= vs_d;
        end
    end

    assign level_ready = ~pending_full_q;
    assign rgb         = rgb_q;
    assign hsync_out   = hs_q;
    assign vsync_out   = vs_q;
    assign frame_tick  = frame_tick_q;

endmodule

// File: doc/vga_bar_render.md
Name: vga_bar_render

Overview:
- Pixel-generation stage directly downstream of the VGA sync controller. Consumes its hc/vc counters and active-low hsync/vsync.
- Draws a vertical biofeedback level bar, a threshold marker and a background into an 8-bit RGB332 stream.
- Sensor level updates arrive on a valid/ready handshake. They are committed only at the start of vertical blanking, and the displayed height slews toward the committed level by a bounded step per frame.
- Output RGB and both syncs are aligned by a fixed 2-cycle pipeline.

Parameters:
- BAR_X, 304, left column of bar (pixels)
- BAR_W, 32, bar width (pixels)
- STEP, 4, max change of displayed level per frame (level units)
- WARN, 160, level at/above which bar is red and at which marker is drawn
- BG_COLOR, 8'h02, active-area background (RGB332)

Ports:
- clk  in  1  pixel clock (25 MHz)
- rst  in  1  synchronous reset, active-high
- hc  in  10  horizontal counter, 0..799, active 0..639
- vc  in  10  vertical counter, 0..524, active 0..479
- hsync_in  in  1  active-low hsync from sync controller
- vsync_in  in  1  active-low vsync from sync controller
- level_in  in  8  new sensor level
- level_valid  in  1  level_in valid
- level_ready  out  1  pending slot empty; transfer when valid&&ready
- rgb  out  8  pixel colour RGB332 {R[2:0],G[2:0],B[1:0]}
- hsync_out  out  1  hsync delayed 2 cycles
- vsync_out  out  1  vsync delayed 2 cycles
- frame_tick  out  1  one-cycle pulse on commit cycle

Behaviour:
- All state updates on posedge clk. rst is sampled synchronously.
- Reset values: rgb=0, hsync_out=1, vsync_out=1, frame_tick=0, pending_full=0, pending=0, target=0, disp=0, so level_ready=1.
- level_ready = ~pending_full, combinational.
- Accept: when level_valid&&level_ready, pending<=level_in and pending_full<=1.
- Commit cycle: hc==0 && vc==480.
  - frame_tick=1 (registered, asserted in the cycle after the commit cycle).
  - If pending_full: target<=pending, pending_full<=0.
  - Accepts cannot collide with a commit that uses pending, because ready=0 while full.
  - If pending was empty and a value is accepted in the commit cycle, it stays pending until the next frame.
- Slew cycle: hc==1 && vc==480, evaluated with the target just committed.
  - If disp<target: disp<=min(disp+STEP, target).
  - If disp>target: disp<=max(disp-STEP, target).
  - Use 9-bit intermediates so there is no wrap at 0/255.
  - disp never changes during active video, so there is no tearing.
- Height: h = min(2*disp, 480) lines, in 9-bit arithmetic. Bar rows are vc in [480-h, 479]; h=0 draws no bar.
- Marker row: m = 480 - min(2*WARN, 480). Marker occupies only the columns hc in [BAR_X-4, BAR_X+BAR_W+3].
- Pixel priority, first match wins:
  1. Outside active area (hc>=640 or vc>=480): 8'h00.
  2. Marker row and marker columns: 8'hFF.
  3. Bar region (hc in [BAR_X, BAR_X+BAR_W-1] and a bar row): 8'hE0 if disp>=WARN, else 8'h1C.
  4. Otherwise: BG_COLOR.
- Pipeline:
  - Stage 1 registers the region compare flags and the syncs.
  - Stage 2 registers rgb and the syncs.
  - Inputs at cycle t appear on rgb/hsync_out/vsync_out at t+2.
- Reset mid-frame: pipeline clears and outputs black with syncs inactive for 2 cycles. Values then resume tracking the inputs, with no need to wait for a frame boundary. Any pending value is discarded.
- hc/vc values outside their stated ranges are treated as blanking (black).

Test Plan:
- Reset, then drive hc=100, vc=100 -> after 2 cycles rgb=8'h02; hsync_out/vsync_out equal inputs delayed exactly 2 cycles over a full 800x525 frame.
- Send level 100 mid-frame -> level_ready drops next cycle. At hc=0, vc=480: target=100, ready=1, frame_tick pulses. Then disp=4, and after 25 frames disp=100: column 320 green (8'h1C) for rows 280..479 and 8'h02 at row 279.
- Set target 200 from disp 0 -> disp crosses 160 in frame 40, when the bar turns red (8'hE0). Marker row 160 at hc=300 reads 8'hFF, and at hc=299 reads 8'h02.
- Levels 255 then 0 -> height clamps at 480 (row 0 is bar colour, except the marker on its row). Descent goes 255→251→… and ends at exactly 0 with no underflow; at 0 no bar row is drawn.
- Offer a second level while pending is full -> no accept (ready=0) until the commit. A value offered in the commit cycle with pending empty is applied only at the next frame's commit.
- Assert rst at hc=400, vc=200 -> rgb=0, syncs=1, ready=1, disp=0. Output resumes 2 cycles after rst deasserts.
